// File: rtl/lfsr_checker.sv
// Receive-side monitor for the 4-bit LFSR pattern generator: locks onto the
// sampled sequence, then flywheels it and counts mismatches.
module lfsr_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] expected, expected_n;
  logic [MW-1:0]    mcnt, mcnt_n, mcnt_inc;
  logic [LW-1:0]    miss, miss_n, miss_inc;
  logic             pulse_n;
  logic [ERR_W-1:0] count_n;

  function automatic logic [WIDTH-1:0] step_lfsr(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign mcnt_inc = mcnt + MW'(1);
  assign miss_inc = miss + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= HUNT;
      expected  <= '0;
      mcnt      <= '0;
      miss      <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      cur_state <= nxt_state;
      expected  <= expected_n;
      mcnt      <= mcnt_n;
      miss      <= miss_n;
      err_pulse <= pulse_n;
      err_count <= count_n;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    expected_n = expected;
    mcnt_n     = mcnt;
    miss_n     = miss;
    pulse_n    = 1'b0;
    count_n    = err_count;
    if (in_valid) begin
      unique case (cur_state)
        HUNT: begin
          if (in_data != '0) begin
            expected_n = step_lfsr(in_data);
            mcnt_n     = MW'(1);
            nxt_state  = SYNC;
          end
        end
        SYNC: begin
          if (in_data == expected) begin
            expected_n = step_lfsr(in_data);
            mcnt_n     = mcnt_inc;
            if (mcnt_inc == MW'(LOCK_CNT)) begin
              nxt_state = LOCKED;
              miss_n    = '0;
            end
          end else if (in_data != '0) begin
            expected_n = step_lfsr(in_data);
            mcnt_n     = MW'(1);
          end else begin
            nxt_state = HUNT;
            mcnt_n    = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked the input never reseeds the sequence.
          expected_n = step_lfsr(expected);
          if (in_data == expected) begin
            miss_n = '0;
          end else begin
            pulse_n = 1'b1;
            miss_n  = miss_inc;
            if (err_count != '1) count_n = err_count + ERR_W'(1);
            if (miss_inc == LW'(LOSS_CNT)) begin
              nxt_state = HUNT;
              mcnt_n    = '0;
              miss_n    = '0;
            end
          end
        end
        default: nxt_state = HUNT;
      endcase
    end
    if (clear) count_n = '0;
  end

  always_comb begin
    state  = cur_state;
    locked = (cur_state == LOCKED);
  end

endmodule
